fp2fix_arbiter: RTL and testbench
=================================

# fp2fix_arbiter

Shares one combinational float32-to-fixed converter between two requesters (channel 0 and channel 1) using round-robin arbitration. Each accepted word is converted in the grant cycle. The result is captured in a one-entry output register tagged with the source channel, and the consumer drains it through a valid/ready handshake. The block sits between the two front-end streams and the fixed-point datapath; the converter itself is instantiated outside and wired to `conv_in`/`conv_out`.

## Interface
- `WORD_LENGTH`, 21, width of the converter's signed fixed-point result
- `CNT_WIDTH`, 16, width of each grant counter (used only when the counter feature is compiled in)

- `clk` input 1: the single clock; all state updates on the rising edge
- `rst_n` input 1: reset, synchronous and active-low
- `req0_valid` input 1: channel 0 holds a float32 word
- `req0_data` input 32: channel 0 IEEE-754 single-precision word
- `req0_ready` output 1: channel 0 word is accepted this cycle
- `req1_valid`, `req1_data`, `req1_ready`: same as channel 0, for channel 1
- `conv_in` output 32: float32 word driven to the external converter
- `conv_out` input WORD_LENGTH: combinational result returned by the converter
- `res_valid` output 1: output register holds a result
- `res_data` output WORD_LENGTH: registered fixed-point result
- `res_id` output 1: source channel of `res_data`
- `res_ready` input 1: consumer accepts the result
- `grant0_cnt`, `grant1_cnt` output CNT_WIDTH: grant counters (only with `FP2FIX_ARB_STATS_EN`)

## Operation
- `slot_free = !res_valid || res_ready`. The output register can load whenever `slot_free` is high.
- Grant, evaluated combinationally and only when `slot_free` is high:
  - Only one `reqN_valid` high: grant channel N.
  - Both high: grant the channel selected by the priority pointer `prio` (0 → channel 0).
  - Neither high: no grant.
- `reqN_ready = slot_free && grant == N`. At most one ready is high per cycle, and ready is never high without its valid.
- `conv_in` is the granted channel's data. When there is no grant, `conv_in` is 32'h0.
- On a grant, at the clock edge:
  - `res_data <= conv_out`
  - `res_id <= N`
  - `res_valid <= 1`
  - `prio <= ~N`: the loser of a contested cycle wins next. A lone grant also hands priority to the other channel.
- If `slot_free` is high and there is no grant: `res_valid <= 0`. `res_data` and `res_id` hold their last values.
- If `slot_free` is low: all state holds and both readies are low (backpressure).
- Requesters must keep `valid` and `data` stable until their `ready` is high. The arbiter does not re-sample a withdrawn request.
- Conversion semantics are owned entirely by the converter. The arbiter neither inspects nor modifies the data.

## Timing
- Latency: a request accepted in cycle T appears on `res_*` in cycle T+1.
- Throughput: one result per cycle while `res_ready` is held high. With both channels continuously valid, grants strictly alternate.
- A simultaneous drain and load in the same cycle is legal. `res_valid` stays high and `res_data` updates, with no bubble.
- Reset values:
  - `res_valid` = 0, `res_data` = 0, `res_id` = 0
  - `prio` = 0
  - both counters = 0
  - `reqN_ready` = 0 while `rst_n` = 0
- Reset mid-operation: a pending result is discarded with no handshake. The next grant after reset follows the `prio` = 0 rule.
- No combinational path exists from `res_ready` to `res_data`. There is a combinational path from `res_ready` and `reqN_valid` to `reqN_ready`.

## Configuration
- `FP2FIX_ARB_STATS_EN` defined:
  - `grant0_cnt` and `grant1_cnt` are present.
  - Each increments by 1 on every handshake of its channel.
  - Each saturates at all-ones and never wraps.
  - Both clear on reset.
- Not defined: the counter ports and registers are absent. All other behaviour is identical.

## Test plan
The bench models the converter as `conv_out = conv_in[WORD_LENGTH-1:0]`.
- **Reset:** hold `rst_n` = 0 for 3 cycles with both channels valid → `res_valid` = 0, `res_data` = 0, both readies 0. On the first cycle after release, `req0_ready` = 1.
- **Single channel:** `req1_valid` = 1, `req1_data` = 32'h3F800000, `res_ready` = 1 → `req1_ready` = 1 in cycle T. In T+1, `res_valid` = 1, `res_id` = 1, `res_data` = 21'h000000.
- **Contention:** both valid for 6 cycles with distinct data (0x00000001..), `res_ready` = 1 → `res_id` sequence 0,1,0,1,0,1 and each `res_data` matches its source word.
- **Backpressure:** result pending and `res_ready` = 0 for 4 cycles → both readies 0 and `res_data` stable. When `res_ready` rises, the next grant loads in the same cycle and `res_valid` stays 1.
- **Reset with pending result:** `res_valid` = 1 and `res_ready` = 0, then `rst_n` = 0 for one cycle → `res_valid` = 0 the next cycle and the result is never delivered.
- **Counter saturation (`FP2FIX_ARB_STATS_EN`, CNT_WIDTH = 4):** 20 channel-0 grants → `grant0_cnt` = 4'hF and `grant1_cnt` = 0.

Source files
------------

// File: rtl/fp2fix_arbiter.sv
// fp2fix_arbiter
//
// Shares one external combinational float32-to-fixed converter between two requesters.
// Arbitration is round-robin. The converter result is captured in a one-entry output
// register tagged with the source channel and is drained through a valid/ready handshake.
//
// Optional feature: define FP2FIX_ARB_STATS_EN to add two saturating grant counters.
//
// Parameters:
//   WORD_LENGTH - width of the converter's signed fixed-point result
//   CNT_WIDTH   - width of each grant counter (only used with FP2FIX_ARB_STATS_EN)
//
// Ports:
//   clk, rst_n                      - clock and synchronous active-low reset
//   req0_valid/req0_data/req0_ready - channel 0 float32 request stream
//   req1_valid/req1_data/req1_ready - channel 1 float32 request stream
//   conv_in                         - word sent to the external converter (0 when idle)
//   conv_out                        - combinational result returned by the converter
//   res_valid/res_data/res_id       - registered result, its source channel and valid flag
//   res_ready                       - consumer accepts the result
//   grant0_cnt, grant1_cnt          - per-channel grant counters (FP2FIX_ARB_STATS_EN only)
module fp2fix_arbiter #(
  parameter int unsigned WORD_LENGTH = 21,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req0_valid,
  input  logic [31:0]            req0_data,
  output logic                   req0_ready,
  input  logic                   req1_valid,
  input  logic [31:0]            req1_data,
  output logic                   req1_ready,
  output logic [31:0]            conv_in,
  input  logic [WORD_LENGTH-1:0] conv_out,
  output logic                   res_valid,
  output logic [WORD_LENGTH-1:0] res_data,
  output logic                   res_id,
  input  logic                   res_ready
`ifdef FP2FIX_ARB_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]   grant0_cnt,
  output logic [CNT_WIDTH-1:0]   grant1_cnt
`endif
);

  logic                   res_valid_q;
  logic [WORD_LENGTH-1:0] res_data_q;
  logic                   res_id_q;
  logic                   prio_q;

  logic slot_free;
  logic grant_valid;
  logic grant_id;

  // The output register may load when empty or when being drained this same cycle.
  assign slot_free = !res_valid_q || res_ready;

  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    // Readies must stay low during reset, so no grant is issued while rst_n is low.
    if (slot_free && rst_n) begin
      unique case ({req1_valid, req0_valid})
        2'b01: begin
          grant_valid = 1'b1;
          grant_id    = 1'b0;
        end
        2'b10: begin
          grant_valid = 1'b1;
          grant_id    = 1'b1;
        end
        2'b11: begin
          grant_valid = 1'b1;
          grant_id    = prio_q;
        end
        default: begin
          grant_valid = 1'b0;
          grant_id    = 1'b0;
        end
      endcase
    end
  end

  assign req0_ready = grant_valid && !grant_id;
  assign req1_ready = grant_valid && grant_id;

  always_comb begin
    conv_in = 32'h0;
    if (grant_valid) begin
      conv_in = grant_id ? req1_data : req0_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= 1'b0;
      prio_q      <= 1'b0;
    end else if (slot_free) begin
      if (grant_valid) begin
        res_valid_q <= 1'b1;
        res_data_q  <= conv_out;
        res_id_q    <= grant_id;
        // Hand priority to the other channel after every grant, contested or not.
        prio_q      <= ~grant_id;
      end else begin
        res_valid_q <= 1'b0;
      end
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;

`ifdef FP2FIX_ARB_STATS_EN
  logic [CNT_WIDTH-1:0] grant0_cnt_q;
  logic [CNT_WIDTH-1:0] grant1_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant0_cnt_q <= '0;
      grant1_cnt_q <= '0;
    end else begin
      // Saturate at all-ones rather than wrapping.
      if (req0_ready && (grant0_cnt_q != '1)) begin
        grant0_cnt_q <= grant0_cnt_q + 1'b1;
      end
      if (req1_ready && (grant1_cnt_q != '1)) begin
        grant1_cnt_q <= grant1_cnt_q + 1'b1;
      end
    end
  end

  assign grant0_cnt = grant0_cnt_q;
  assign grant1_cnt = grant1_cnt_q;
`else
  // Counter width is meaningless without the statistics feature.
  logic unused_cnt_width;
  assign unused_cnt_width = ^CNT_WIDTH;
`endif

endmodule

// File: tb/tb_fp2fix_arbiter.sv
// Directed self-checking bench for fp2fix_arbiter. The converter is modelled as a
// truncation of conv_in to WORD_LENGTH bits.
module tb_fp2fix_arbiter;

  localparam int unsigned WordLength = 21;
  localparam int unsigned CntWidth   = 4;

  logic                  clk;
  logic                  rst_n;
  logic                  req0_valid;
  logic [31:0]           req0_data;
  logic                  req0_ready;
  logic                  req1_valid;
  logic [31:0]           req1_data;
  logic                  req1_ready;
  logic [31:0]           conv_in;
  logic [WordLength-1:0] conv_out;
  logic                  res_valid;
  logic [WordLength-1:0] res_data;
  logic                  res_id;
  logic                  res_ready;
`ifdef FP2FIX_ARB_STATS_EN
  logic [CntWidth-1:0]   grant0_cnt;
  logic [CntWidth-1:0]   grant1_cnt;
`endif

  int n_assert;
  int n_fail;

  assign conv_out = conv_in[WordLength-1:0];

  fp2fix_arbiter #(
    .WORD_LENGTH (WordLength),
    .CNT_WIDTH   (CntWidth)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .conv_in    (conv_in),
    .conv_out   (conv_out),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_id     (res_id),
    .res_ready  (res_ready)
`ifdef FP2FIX_ARB_STATS_EN
    ,
    .grant0_cnt (grant0_cnt),
    .grant1_cnt (grant1_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_assert   = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_data  = 32'h0000_0011;
    req1_data  = 32'h0000_0022;
    res_ready  = 1'b1;

    // Reset held for 3 cycles with both channels requesting.
    repeat (3) tick();
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_req0_ready", req0_ready, 0);
    check("rst_req1_ready", req1_ready, 0);
    rst_n = 1'b1;
    #1;
    check("post_rst_req0_ready", req0_ready, 1);
    check("post_rst_req1_ready", req1_ready, 0);
    check("post_rst_conv_in", conv_in, 32'h11);
    tick();
    check("first_res_valid", res_valid, 1);
    check("first_res_id", res_id, 0);
    check("first_res_data", res_data, 32'h11);
    check("alt_req1_ready", req1_ready, 1);
    tick();
    check("second_res_id", res_id, 1);
    check("second_res_data", res_data, 32'h22);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    check("idle_req0_ready", req0_ready, 0);
    check("idle_req1_ready", req1_ready, 0);
    check("idle_conv_in", conv_in, 0);
    tick();
    check("idle_res_valid", res_valid, 0);
    check("idle_res_data_hold", res_data, 32'h22);

    // Single channel 1 request.
    req1_valid = 1'b1;
    req1_data  = 32'h3F80_0000;
    #1;
    check("single_req1_ready", req1_ready, 1);
    check("single_req0_ready", req0_ready, 0);
    tick();
    req1_valid = 1'b0;
    check("single_res_valid", res_valid, 1);
    check("single_res_id", res_id, 1);
    check("single_res_data", res_data, 32'h0);
    tick();
    check("single_drained", res_valid, 0);

    // Contention: grants must alternate 0,1,0,1,0,1.
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_data  = 32'h1;
    req1_data  = 32'h2;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("cont_id_%0d", i), res_id, i % 2);
      check($sformatf("cont_data_%0d", i), res_data, i + 1);
      if (i % 2 == 0) req0_data = req0_data + 32'd2;
      else req1_data = req1_data + 32'd2;
    end

    // Backpressure with a pending result (data 6); both channels still valid.
    res_ready = 1'b0;
    #1;
    check("bp_req0_ready", req0_ready, 0);
    check("bp_req1_ready", req1_ready, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("bp_r0_%0d", i), req0_ready, 0);
      check($sformatf("bp_r1_%0d", i), req1_ready, 0);
      check($sformatf("bp_data_%0d", i), res_data, 32'h6);
      check($sformatf("bp_valid_%0d", i), res_valid, 1);
    end
    res_ready = 1'b1;
    #1;
    check("bp_release_req0_ready", req0_ready, 1);
    tick();
    check("bp_release_valid", res_valid, 1);
    check("bp_release_data", res_data, 32'h7);
    check("bp_release_id", res_id, 0);

    // Reset with a pending result; priority pointer was 1 before reset.
    res_ready  = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst_n      = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst_pend_valid", res_valid, 0);
    check("rst_pend_data", res_data, 0);
    tick();
    check("rst_pend_still_empty", res_valid, 0);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_data  = 32'h0000_1234;
    req1_data  = 32'h0000_5678;
    res_ready  = 1'b1;
    #1;
    check("rst_prio_req0_ready", req0_ready, 1);
    check("rst_prio_req1_ready", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    check("rst_prio_data", res_data, 32'h1234);
    tick();
    req1_valid = 1'b0;
    check("after_rst_id", res_id, 1);
    check("after_rst_data", res_data, 32'h5678);

`ifdef FP2FIX_ARB_STATS_EN
    // Counter saturation: 20 channel-0 grants on a 4-bit counter.
    rst_n = 1'b0;
    tick();
    check("cnt_rst_g0", grant0_cnt, 0);
    check("cnt_rst_g1", grant1_cnt, 0);
    rst_n      = 1'b1;
    req0_valid = 1'b1;
    req0_data  = 32'h55;
    repeat (5) tick();
    check("cnt_g0_5", grant0_cnt, 5);
    repeat (15) tick();
    req0_valid = 1'b0;
    check("cnt_g0_sat", grant0_cnt, 4'hF);
    check("cnt_g1_zero", grant1_cnt, 0);
    tick();
    check("cnt_g0_hold", grant0_cnt, 4'hF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
